// File: rtl/vx_tcu_drl_exp_align.sv
// Exponent alignment for the TCU dot-product path: per-term exponents, the
// maximum over non-zero terms, and the per-term right shift against it.
// Latency 2 cycles; one global stall (ready_in = ~valid_out | ready_out) holds both stages.
module vx_tcu_drl_exp_align #(
  parameter int NUM_LANES = 8,
  parameter int EXP_W     = 10,
  parameter int SHIFT_W   = 6,
  parameter int W         = 25,
  parameter int WA        = 28
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cfg_we,
  input  logic [2:0]                     cfg_fmt,
  input  logic [EXP_W-1:0]               cfg_bias,
  input  logic                           valid_in,
  output logic                           ready_in,
  input  logic [2:0]                     fmt_in,
  input  logic [NUM_LANES*8-1:0]         ea_in,
  input  logic [NUM_LANES*8-1:0]         eb_in,
  input  logic [NUM_LANES-1:0]           zero_in,
  input  logic [7:0]                     c_exp_in,
  input  logic                           c_zero_in,
  output logic                           valid_out,
  input  logic                           ready_out,
  output logic [EXP_W-1:0]               max_exp_out,
  output logic [NUM_LANES*SHIFT_W-1:0]   shift_out,
  output logic [SHIFT_W-1:0]             c_shift_out,
  output logic [NUM_LANES:0]             sat_out,
  output logic                           all_zero_out
);

  // Term NUM_LANES is the C addend; lanes 0..NUM_LANES-1 are products.
  localparam int NT = NUM_LANES + 1;
  localparam logic [SHIFT_W-1:0] SHIFT_MAX   = '1;
  localparam logic [EXP_W:0]     SHIFT_MAX_X = (EXP_W+1)'(2**SHIFT_W - 1);
  localparam logic [EXP_W-1:0]   C_ADJ       = EXP_W'(WA - W);

  localparam logic [2:0] FMT_FP16 = 3'd1;
  localparam logic [2:0] FMT_BF16 = 3'd2;
  localparam logic [2:0] FMT_FP8  = 3'd3;
  localparam logic [2:0] FMT_BF8  = 3'd4;
  localparam logic [2:0] FMT_TF32 = 3'd5;

  function automatic logic [EXP_W-1:0] bias_default(input logic [2:0] f);
    case (f)
      FMT_TF32: bias_default = EXP_W'(-124);
      FMT_FP16: bias_default = EXP_W'(100);
      FMT_BF16: bias_default = EXP_W'(-124);
      FMT_FP8:  bias_default = EXP_W'(117);
      FMT_BF8:  bias_default = EXP_W'(101);
      default:  bias_default = '0;
    endcase
  endfunction

  logic                 enable;
  logic                 accept;
  logic [EXP_W-1:0]     bias_tbl [8];

  logic                 v1;
  logic [EXP_W-1:0]     e1 [NT];
  logic [NT-1:0]        z1;
  logic [EXP_W-1:0]     e_next [NT];

  logic [EXP_W-1:0]           max_d;
  logic                       any_d;
  logic [NUM_LANES*SHIFT_W-1:0] shift_d;
  logic [SHIFT_W-1:0]         c_shift_d;
  logic [NT-1:0]              sat_d;
  logic [EXP_W:0]             diff;
  logic [SHIFT_W-1:0]         sh;

  assign enable   = ~valid_out | ready_out;
  assign ready_in = enable;
  assign accept   = valid_in & enable;

  // Bias table: a write lands at the edge, so a same-cycle accept still reads the old entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) bias_tbl[i] <= bias_default(3'(i));
    end else if (cfg_we) begin
      bias_tbl[cfg_fmt] <= cfg_bias;
    end
  end

  // Stage-1 term exponents, wrapped to EXP_W bits.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      e_next[i] = EXP_W'(ea_in[i*8 +: 8]) + EXP_W'(eb_in[i*8 +: 8]) + bias_tbl[fmt_in];
    end
    e_next[NUM_LANES] = EXP_W'(c_exp_in) + C_ADJ;
  end

  // Stage-1 register: exponents and zero flags captured on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
      z1 <= '0;
      for (int i = 0; i < NT; i++) e1[i] <= '0;
    end else if (enable) begin
      v1 <= accept;
      if (accept) begin
        z1 <= {c_zero_in, zero_in};
        for (int i = 0; i < NT; i++) e1[i] <= e_next[i];
      end
    end
  end

  // Signed max over non-zero terms, then per-term saturating shift; no live term gives max 0.
  always_comb begin
    max_d     = '0;
    any_d     = 1'b0;
    shift_d   = '0;
    c_shift_d = '0;
    sat_d     = '0;
    diff      = '0;
    sh        = '0;
    for (int i = 0; i < NT; i++) begin
      if (!z1[i] && (!any_d || $signed(e1[i]) > $signed(max_d))) begin
        max_d = e1[i];
        any_d = 1'b1;
      end
    end
    for (int i = 0; i < NT; i++) begin
      // One extra bit so max - e cannot wrap even across the full signed range.
      diff = {max_d[EXP_W-1], max_d} - {e1[i][EXP_W-1], e1[i]};
      if (z1[i] || diff > SHIFT_MAX_X) begin
        sh       = SHIFT_MAX;
        sat_d[i] = 1'b1;
      end else begin
        sh       = diff[SHIFT_W-1:0];
      end
      if (i < NUM_LANES) shift_d[i*SHIFT_W +: SHIFT_W] = sh;
      else               c_shift_d = sh;
    end
  end

  // Stage-2 output register; holds while downstream stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out    <= 1'b0;
      max_exp_out  <= '0;
      shift_out    <= '0;
      c_shift_out  <= '0;
      sat_out      <= '0;
      all_zero_out <= 1'b0;
    end else if (enable) begin
      valid_out <= v1;
      if (v1) begin
        max_exp_out  <= max_d;
        shift_out    <= shift_d;
        c_shift_out  <= c_shift_d;
        sat_out      <= sat_d;
        all_zero_out <= ~any_d;
      end
    end
  end

endmodule
